// File: rtl/seg_dec_pkg.sv
// rtl/seg_dec_pkg.sv - shared 7-segment pattern and anode constants for display checkers
package seg_dec_pkg;

    // Active-high gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] AN_DIG0 = 4'he;
    localparam logic [3:0] AN_DIG1 = 4'hd;
    localparam logic [3:0] AN_DIG2 = 4'hb;
    localparam logic [3:0] AN_DIG3 = 4'h7;
    localparam logic [3:0] AN_IDLE = 4'hf;

    typedef struct packed {
        logic [3:0] value;
        logic       legal;
        logic       blank;
    } seg_dec_t;

    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        case (v)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational active-high segment pattern to {value, legal, blank}
module seg_pattern_decode
    import seg_dec_pkg::*;
(
    input  logic [6:0] pattern_i,
    output seg_dec_t   dec_o
);

    always_comb begin
        dec_o = '0;
        if (pattern_i == SEG_BLANK) begin
            dec_o.blank = 1'b1;
        end else begin
            for (int v = 0; v < 16; v++) begin
                if (pattern_i == seg_pattern(v[3:0])) begin
                    dec_o.value = v[3:0];
                    dec_o.legal = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment monitor; SEG_DEC_TIMEOUT_EN adds per-digit valid timeout
module seg_scan_decoder
    import seg_dec_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anodes,
    input  logic [6:0] segs,
    input  logic       decimalPt,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] dp,
    output logic [3:0] digValid,
    output logic [3:0] blank,
    output logic       upd,
    output logic       segErr
);

    localparam int         SW          = $clog2(STABLE_CYCLES);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [11:0] IDLE_WORD  = {AN_IDLE, 7'h7f, 1'b1};

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("seg_scan_decoder: parameter out of range");
    end

    logic [11:0]   sync1_q, sync2_q, prev_q, acc_word_q;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic          accept_q, accept_d;

    always_comb begin
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        accept_d = 1'b0;
        if (sync2_q != prev_q) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            // Counter saturates at the acceptance point; disarming prevents re-acceptance
            if (cnt_q == STABLE_LAST) begin
                accept_d = 1'b1;
                armed_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    logic [3:0] acc_an;
    logic [6:0] acc_seg;
    logic       acc_dp;
    seg_dec_t   dec;

    assign acc_an  = acc_word_q[11:8];
    assign acc_seg = ~acc_word_q[7:1];
    assign acc_dp  = ~acc_word_q[0];

    seg_pattern_decode u_pattern_decode (
        .pattern_i (acc_seg),
        .dec_o     (dec)
    );

    logic [3:0] hex_q [4];
    logic [3:0] hex_d [4];
    logic [3:0] dp_q, dp_d, valid_q, valid_d, blank_q, blank_d, seen_q, seen_d;
    logic       upd_q, upd_d, err_q, err_d;
    logic       dig_hit;
    logic [1:0] dig_idx;

`ifdef SEG_DEC_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q [4];
    logic [TW-1:0] tmo_d [4];
`endif

    always_comb begin
        hex_d   = hex_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        blank_d = blank_q;
        seen_d  = seen_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        dig_hit = 1'b0;
        dig_idx = 2'd0;
        case (acc_an)
            AN_DIG0: begin dig_hit = 1'b1; dig_idx = 2'd0; end
            AN_DIG1: begin dig_hit = 1'b1; dig_idx = 2'd1; end
            AN_DIG2: begin dig_hit = 1'b1; dig_idx = 2'd2; end
            AN_DIG3: begin dig_hit = 1'b1; dig_idx = 2'd3; end
            default: ;
        endcase

`ifdef SEG_DEC_TIMEOUT_EN
        tmo_d = tmo_q;
        for (int n = 0; n < 4; n++) begin
            if (tmo_q[n] != '0) begin
                tmo_d[n] = tmo_q[n] - 1'b1;
            end
            if (tmo_q[n] == TW'(1)) begin
                valid_d[n] = 1'b0;
                upd_d      = 1'b1;
            end
        end
`endif

        // Acceptance is evaluated last so a refresh wins over a coincident timeout
        if (accept_q) begin
            if (dig_hit) begin
                if (dec.legal || dec.blank) begin
                    if (dec.legal) begin
                        hex_d[dig_idx] = dec.value;
                    end
                    blank_d[dig_idx] = dec.blank;
                    dp_d[dig_idx]    = acc_dp;
                    valid_d[dig_idx] = 1'b1;
                    seen_d[dig_idx]  = 1'b1;
                    upd_d = upd_d | !seen_q[dig_idx]
                          | (hex_d[dig_idx]   != hex_q[dig_idx])
                          | (dp_d[dig_idx]    != dp_q[dig_idx])
                          | (blank_d[dig_idx] != blank_q[dig_idx]);
`ifdef SEG_DEC_TIMEOUT_EN
                    tmo_d[dig_idx] = TMO_LAST;
`endif
                end else begin
                    err_d            = 1'b1;
                    valid_d[dig_idx] = 1'b0;
                end
            end else if (acc_an != AN_IDLE) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= IDLE_WORD;
            sync2_q    <= IDLE_WORD;
            prev_q     <= IDLE_WORD;
            acc_word_q <= IDLE_WORD;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            accept_q   <= 1'b0;
            hex_q      <= '{default: '0};
            dp_q       <= '0;
            valid_q    <= '0;
            blank_q    <= '0;
            seen_q     <= '0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef SEG_DEC_TIMEOUT_EN
            tmo_q      <= '{default: '0};
`endif
        end else begin
            sync1_q  <= {anodes, segs, decimalPt};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            accept_q <= accept_d;
            if (accept_d) begin
                acc_word_q <= prev_q;
            end
            hex_q    <= hex_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            seen_q   <= seen_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
`ifdef SEG_DEC_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign dp       = dp_q;
    assign digValid = valid_q;
    assign blank    = blank_q;
    assign upd      = upd_q;
    assign segErr   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] anodes;
    logic [6:0] segs;
    logic       decimalPt;
    logic [3:0] hex0, hex1, hex2, hex3, dp, digValid, blank;
    logic       upd, segErr;

    int checks = 0;
    int errors = 0;
    int upd_total = 0;
    int err_total = 0;
    int u0, e0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYCLES  (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .anodes    (anodes),
        .segs      (segs),
        .decimalPt (decimalPt),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .dp        (dp),
        .digValid  (digValid),
        .blank     (blank),
        .upd       (upd),
        .segErr    (segErr)
    );

    always @(posedge clk) begin
        if (upd === 1'b1)    upd_total <= upd_total + 1;
        if (segErr === 1'b1) err_total <= err_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] pat, input logic dpn);
        anodes    = an;
        segs      = ~pat;
        decimalPt = dpn;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hex"},   {hex3, hex2, hex1, hex0}, 32'h0);
        check({tag, "_dp"},    dp, 32'h0);
        check({tag, "_valid"}, digValid, 32'h0);
        check({tag, "_blank"}, blank, 32'h0);
        check({tag, "_upd"},   upd, 32'h0);
        check({tag, "_err"},   segErr, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(4'hf, 7'h00, 1'b1);
        cyc(3);
        check_reset_outputs("rst");

        // Digit 0 = 2; first sampling edge is cycle 0, upd expected after edge 19
        rst = 1'b0;
        drive(4'he, 7'h5B, 1'b1);
        u0 = upd_total;
        cyc(19);
        check("d0_upd_early", upd, 32'h0);
        cyc(1);
        check("d0_upd_at19", upd, 32'h1);
        check("d0_hex0", hex0, 32'h2);
        check("d0_valid", digValid, 32'h1);
        check("d0_dp", dp, 32'h0);
        check("d0_blank", blank, 32'h0);
        cyc(10);
        check("d0_upd_count", upd_total - u0, 32'h1);

`ifdef SEG_DEC_TIMEOUT_EN
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        drive(4'h7, 7'h07, 1'b1);
        u0 = upd_total;
        cyc(20);
        check("to_hex3", hex3, 32'h7);
        check("to_valid_set", digValid, 32'h8);
        drive(4'hf, 7'h00, 1'b1);
        cyc(98);
        check("to_valid_hold", digValid, 32'h8);
        cyc(1);
        check("to_valid_drop", digValid, 32'h0);
        check("to_upd_pulse", upd, 32'h1);
        cyc(5);
        check("to_upd_count", upd_total - u0, 32'h2);
`else
        u0 = upd_total;
        for (int r = 0; r < 2; r++) begin
            drive(4'he, 7'h06, 1'b1);
            cyc(100);
            drive(4'hd, 7'h79, 1'b0);
            cyc(100);
        end
        check("alt_hex0", hex0, 32'h1);
        check("alt_hex1", hex1, 32'hE);
        check("alt_valid", digValid, 32'h3);
        check("alt_dp", dp, 32'h2);
        check("alt_upd_count", upd_total - u0, 32'h2);

        drive(4'he, 7'h4F, 1'b1);
        cyc(40);
        check("gl_hex0_pre", hex0, 32'h3);
        u0 = upd_total;
        e0 = err_total;
        drive(4'he, 7'h7F, 1'b1);
        cyc(5);
        drive(4'he, 7'h4F, 1'b1);
        cyc(40);
        check("gl_hex0_post", hex0, 32'h3);
        check("gl_upd_none", upd_total - u0, 32'h0);
        check("gl_err_none", err_total - e0, 32'h0);

        u0 = upd_total;
        e0 = err_total;
        drive(4'hc, 7'h4F, 1'b1);
        cyc(30);
        check("an_err_count", err_total - e0, 32'h1);
        check("an_upd_none", upd_total - u0, 32'h0);
        check("an_hex", {hex3, hex2, hex1, hex0}, 32'h00E3);
        check("an_valid", digValid, 32'h3);

        drive(4'hb, 7'h7C, 1'b1);
        cyc(30);
        check("d2_hex2", hex2, 32'hB);
        check("d2_valid", digValid, 32'h7);
        u0 = upd_total;
        e0 = err_total;
        drive(4'hb, 7'h01, 1'b1);
        cyc(30);
        check("seg_err_count", err_total - e0, 32'h1);
        check("seg_upd_none", upd_total - u0, 32'h0);
        check("seg_valid", digValid, 32'h3);
        check("seg_hex2", hex2, 32'hB);

        u0 = upd_total;
        drive(4'h7, 7'h00, 1'b1);
        cyc(30);
        check("bl_blank", blank, 32'h8);
        check("bl_valid", digValid, 32'hB);
        check("bl_hex3", hex3, 32'h0);
        check("bl_upd_count", upd_total - u0, 32'h1);
`endif

        // Reset in the middle of a stable window
        drive(4'hd, 7'h6D, 1'b1);
        cyc(12);
        rst = 1'b1;
        cyc(2);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        cyc(19);
        check("rel_upd_early", upd, 32'h0);
        check("rel_hex1_early", hex1, 32'h0);
        cyc(1);
        check("rel_upd_at19", upd, 32'h1);
        check("rel_hex1", hex1, 32'h5);
        check("rel_valid", digValid, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the 4-digit multiplexed 7-segment driver. Samples the scanned anode/segment/decimal-point lines, filters them for stability, and reconstructs the per-digit hex values together with per-digit valid flags and error reporting. Used as an on-board display monitor and as a checker that closes the loop on the display driver in system benches.

## Interface
- STABLE_CYCLES, 16: consecutive identical samples required before a scan state is accepted; legal range 2..65535.
- TIMEOUT_CYCLES, 4000000: cycles without a refresh after which a digit's valid flag clears. Used only with SEG_DEC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- anodes  in  4  digit enables, active low; bit n selects digit n.
- segs  in  7  cathodes, active low; segs[0]=A … segs[6]=G.
- decimalPt  in  1  decimal point, active low.
- hex0, hex1, hex2, hex3  out  4 each  last accepted value of each digit.
- dp  out  4  last accepted decimal-point state per digit, active high.
- digValid  out  4  digit n holds a valid decoded value.
- blank  out  4  digit n was last accepted with all segments off.
- upd  out  1  one-cycle pulse when any hex/dp/blank register changes value.
- segErr  out  1  one-cycle pulse on acceptance of an illegal pattern or an illegal anode code.

## Operation
- Input path: {anodes, segs, decimalPt} is passed through a 2-flop synchronizer. The synchronizer resets to idle: anodes 4'hf, segs 7'h7f, decimalPt 1.
- Stability filter:
  - The synchronized word S is compared with its previous value S_q every cycle.
  - On mismatch: counter := 0 and armed := 1.
  - On match while armed: counter increments. When the counter reaches STABLE_CYCLES-1, the state is accepted for one cycle and armed := 0.
  - A state is accepted exactly once per stable episode.
  - Reset: counter 0, armed 1.
- Anode classification at acceptance:
  - 4'hf (idle): no effect.
  - Exactly one bit low: digit n is addressed.
  - Any other code: segErr pulse; no register changes.
- Segment decode (active-high gfedcba) → value:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - 00 → blank: blank[n] := 1, digValid[n] := 1, hex unchanged.
  - A legal value → hex[n] := value, blank[n] := 0, digValid[n] := 1.
  - Any other pattern → segErr pulse. digit n is unchanged except digValid[n] := 0.
- dp[n] := ~decimalPt is written whenever digit n is accepted without a segment error.
- upd pulses in the cycle after acceptance if any of hex[n], dp[n] or blank[n] changed. A first acceptance after reset always counts as a change.

## Timing
- Reset values:
  - hex0..3 = 0, dp = 0, blank = 0, digValid = 0.
  - upd = 0, segErr = 0, all timeout counters = 0.
- Latency: a pin change that is held steady is reflected on the outputs STABLE_CYCLES+3 cycles after the first clock that samples it (2 synchronizer cycles, the filter, 1 output register).
- An input glitch shorter than STABLE_CYCLES produces no output change.
- upd and segErr are registered and mutually exclusive for a given acceptance; each is high for exactly one cycle.
- Reset asserted mid-filter or mid-timeout discards all state. The next acceptance requires a full STABLE_CYCLES window after rst deasserts.
- Counter widths are $clog2(STABLE_CYCLES) and $clog2(TIMEOUT_CYCLES). The stability counter saturates and never wraps.

## Configuration
- SEG_DEC_TIMEOUT_EN defined:
  - Each digit has a down-counter that is reloaded to TIMEOUT_CYCLES-1 on every acceptance of that digit.
  - When the counter reaches 0: digValid[n] := 0 and upd pulses once. The counter holds at 0 until the digit is next accepted.
  - An en7Seg=0 (all anodes high) period therefore invalidates all digits after the timeout.
- SEG_DEC_TIMEOUT_EN undefined: no timeout counters; digValid is cleared only by reset or an illegal segment pattern.

## Structure
- The shared package seg_dec_pkg holds:
  - the 16 segment pattern constants and the blank pattern;
  - the anode codes for digits 0–3 (4'he, 4'hd, 4'hb, 4'h7) and the idle code 4'hf.
- The pattern→{value, legal, blank} lookup is a combinational sub-module, seg_pattern_decode, which can be reused by other display checkers.

## Test plan
- After rst, hold anodes=4'he, segs=~7'h5B for 20 cycles → hex0=2, digValid=4'b0001, one upd pulse at cycle 19 after the first sampled cycle.
- Alternate digit 0 = segs ~7'h06 and digit 1 = segs ~7'h79, each held 100 cycles → hex0=1, hex1=E, digValid=4'b0011. Only 2 upd pulses total; repeats produce none.
- Hold digit 0 value 3, then apply a 5-cycle glitch of segs=~7'h7F → hex0 stays 3, no upd.
- anodes=4'hc held 20 cycles → one segErr pulse, outputs unchanged. Then segs=~7'h01 on digit 2 → segErr, digValid[2]=0.
- With SEG_DEC_TIMEOUT_EN and TIMEOUT_CYCLES=100: accept digit 3, then hold anodes=4'hf → digValid[3] drops 100 cycles after acceptance, one upd pulse.
- Assert rst during a 10-cycle-old stable window → all outputs return to reset values. Acceptance occurs only STABLE_CYCLES after release.
